sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one synchronous SRAM port between the instruction-fetch requester (pc_reg/icache) and
//  the data requester (ex stage load/store). Serialises accesses, tags each read and routes the
//  response back to its owner. Raises a stall request to ctrl while a data access is waiting or
//  in flight. Drops an instruction response when the pipeline is flushed.
// PARAMETERS
//  RD_LAT     1  SRAM read latency in cycles, grant cycle to rdata-valid cycle; legal 1..7
//  DATA_BURST 4  max consecutive data grants while inst_req is waiting; legal 1..15
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  flush        in   1   pipeline flush from ctrl
//  inst_req     in   1   fetch request, held until inst_gnt
//  inst_addr    in   32  fetch address
//  inst_gnt     out  1   fetch accepted this cycle
//  inst_rvalid  out  1   inst_rdata valid this cycle
//  inst_rdata   out  32  fetched word
//  data_req     in   1   data request, held until data_gnt
//  data_wen     in   4   byte write enables; 4'b0000 = read
//  data_addr    in   32  data address
//  data_wdata   in   32  store data
//  data_gnt     out  1   data access accepted this cycle
//  data_rvalid  out  1   data_rdata valid this cycle (reads only)
//  data_rdata   out  32  load word
//  mem_en       out  1   SRAM enable
//  mem_wen      out  4   SRAM byte write enables
//  mem_addr     out  32  SRAM address
//  mem_wdata    out  32  SRAM write data
//  mem_rdata    in   32  SRAM read data, valid RD_LAT cycles after mem_en
//  stallreq_o   out  1   stall request to ctrl
// BEHAVIOUR
//  - Reset: state IDLE, lat_cnt=0, burst_cnt=0, drop=0. While rst=1 all gnt, rvalid, mem_en,
//    mem_wen and stallreq_o are 0. All data/address outputs are 0 whenever their strobe is 0.
//  - FSM: IDLE, WAIT_I (inst read pending), WAIT_D (data read pending).
//  - Port free: state==IDLE, or lat_cnt==1 in WAIT_I/WAIT_D (response cycle; back-to-back allowed).
//  - Grant (combinational, only when port free and rst=0):
//    data wins unless inst_req=1 and burst_cnt==DATA_BURST; then inst wins.
//    inst_gnt is forced 0 while flush=1. At most one gnt per cycle.
//  - mem_en = inst_gnt|data_gnt. mem_addr/mem_wen/mem_wdata come from the winner.
//    inst grant drives mem_wen=0.
//  - burst_cnt: +1 (saturating) on data_gnt while inst_req=1; cleared on inst_gnt or when inst_req=0.
//  - Read grant: next state WAIT_I/WAIT_D, lat_cnt<=RD_LAT. Decrement each cycle in WAIT_*.
//    Response cycle is lat_cnt==1: owner rvalid=1, rdata=mem_rdata (passthrough);
//    next state per same-cycle grant, else IDLE.
//  - Write grant (data_wen!=0): completes in grant cycle, no rvalid. State stays/returns IDLE.
//  - Latency: read response exactly RD_LAT cycles after gnt; sustained throughput 1 read per
//    RD_LAT cycles, 1 write per cycle.
//  - flush=1 in WAIT_I sets drop; the pending inst response asserts no inst_rvalid.
//    drop clears on the response cycle. flush does not affect data accesses or WAIT_D.
//  - stallreq_o = (data_req & ~data_gnt) | (state==WAIT_D & ~data_rvalid).
//  - Reset asserted mid-transaction aborts it: no rvalid is emitted for the aborted access.
// TESTING
//  - RD_LAT=1: inst_req @0x00000100 alone -> inst_gnt cyc0, mem_addr=0x100, inst_rvalid cyc1
//    with mem_rdata.
//  - Both req same cycle, data read @0x80 -> data_gnt, stallreq_o=1 until data_rvalid;
//    inst_gnt in the data response cycle.
//  - data_req held high 10 cycles of writes, inst_req high, DATA_BURST=4 -> 4 data_gnt,
//    1 inst_gnt, repeat.
//  - RD_LAT=3: inst read gnt cyc0, flush cyc1 -> no inst_rvalid cyc3; next inst_gnt cyc3
//    (flush low) answered cyc6.
//  - Store wen=4'b0011 @0x1000, wdata=0xDEADBEEF -> mem_en=1, mem_wen=0011 same cycle;
//    no data_rvalid; port free next cycle.
//  - rst=1 during WAIT_D -> outputs 0 next edge, no data_rvalid; first request after reset
//    granted immediately.

Source files
------------

// File: rtl/sram_port_if.sv
// Purpose : request/response bundle between the fetch/data requesters, the SRAM
//           port arbiter and the single synchronous SRAM port.
// Ports   : inst_* fetch channel, data_* load/store channel, mem_* SRAM port,
//           flush in from ctrl, stallreq_o out to ctrl.
interface sram_port_if;
   logic        flush;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stallreq_o;

   // arbiter side
   modport slave (
      input  flush, inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, mem_rdata,
      output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
             mem_en, mem_wen, mem_addr, mem_wdata, stallreq_o
   );

   // requester / SRAM side
   modport master (
      output flush, inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, mem_rdata,
      input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
             mem_en, mem_wen, mem_addr, mem_wdata, stallreq_o
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose : shares one SRAM port between fetch and data requesters, tags reads, routes responses.
// Latency : grant is combinational; read data returns RD_LAT cycles after grant, writes finish in the grant cycle.
// Backpr. : requests are held until gnt; data has priority except after DATA_BURST grants with fetch waiting.
// Ports   : clk, rst (sync, active-high); bus = sram_port_if.slave (inst_*, data_*, mem_*, flush, stallreq_o).
module sram_port_arbiter #(
   parameter int RD_LAT     = 1,
   parameter int DATA_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   sram_port_if.slave  bus
);
   localparam logic [2:0] LAT_INIT  = 3'(RD_LAT);
   localparam logic [3:0] BURST_MAX = 4'(DATA_BURST);

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

   state_t     state, state_nxt;
   logic [2:0] lat_cnt, lat_cnt_nxt;
   logic [3:0] burst_cnt, burst_cnt_nxt;
   logic       drop, drop_nxt;

   logic resp_cyc, port_free, inst_turn, inst_gnt, data_gnt;
   logic inst_rv, data_rv;

   // The response cycle also frees the port so reads can run back-to-back.
   assign resp_cyc  = (state != IDLE) && (lat_cnt == 3'd1);
   assign port_free = (state == IDLE) || resp_cyc;

   // Fetch only takes precedence once data has used up its burst allowance, and
   // never while flushing; in that case the data requester keeps the port.
   assign inst_turn = bus.inst_req & (burst_cnt == BURST_MAX) & ~bus.flush;
   assign inst_gnt  = ~rst & port_free & bus.inst_req & ~bus.flush & (~bus.data_req | inst_turn);
   assign data_gnt  = ~rst & port_free & bus.data_req & ~inst_turn;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         burst_cnt <= '0;
         drop      <= 1'b0;
      end else begin
         state     <= state_nxt;
         lat_cnt   <= lat_cnt_nxt;
         burst_cnt <= burst_cnt_nxt;
         drop      <= drop_nxt;
      end
   end

   // next-state
   always_comb begin
      state_nxt     = IDLE;
      lat_cnt_nxt   = '0;
      burst_cnt_nxt = burst_cnt;
      drop_nxt      = drop;

      if (inst_gnt) begin
         state_nxt   = WAIT_I;
         lat_cnt_nxt = LAT_INIT;
      end else if (data_gnt && (bus.data_wen == 4'b0000)) begin
         state_nxt   = WAIT_D;
         lat_cnt_nxt = LAT_INIT;
      end else if ((state != IDLE) && (lat_cnt > 3'd1)) begin
         state_nxt   = state;
         lat_cnt_nxt = lat_cnt - 3'd1;
      end

      // A flush anywhere in the fetch wait window kills that one response.
      if (state == WAIT_I) begin
         if (lat_cnt == 3'd1)
            drop_nxt = 1'b0;
         else if (bus.flush)
            drop_nxt = 1'b1;
      end

      if (inst_gnt || !bus.inst_req)
         burst_cnt_nxt = '0;
      else if (data_gnt && (burst_cnt != BURST_MAX))
         burst_cnt_nxt = burst_cnt + 4'd1;
   end

   // outputs
   always_comb begin
      inst_rv = ~rst & (state == WAIT_I) & resp_cyc & ~drop & ~bus.flush;
      data_rv = ~rst & (state == WAIT_D) & resp_cyc;

      bus.inst_gnt    = inst_gnt;
      bus.data_gnt    = data_gnt;
      bus.mem_en      = inst_gnt | data_gnt;
      bus.mem_wen     = '0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      if (inst_gnt) begin
         bus.mem_addr  = bus.inst_addr;
      end else if (data_gnt) begin
         bus.mem_addr  = bus.data_addr;
         bus.mem_wen   = bus.data_wen;
         bus.mem_wdata = bus.data_wdata;
      end

      bus.inst_rvalid = inst_rv;
      bus.inst_rdata  = inst_rv ? bus.mem_rdata : '0;
      bus.data_rvalid = data_rv;
      bus.data_rdata  = data_rv ? bus.mem_rdata : '0;
      bus.stallreq_o  = ~rst & ((bus.data_req & ~data_gnt) | ((state == WAIT_D) & ~data_rv));
   end
endmodule
